// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register pending-write scoreboard for ID.
// Optional write-through bypass of the writeback port: RF_WB_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int PEND_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [NRD*5-1:0]    rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  output logic                hazard_o,
  input  logic                iss_valid_i,
  input  logic [4:0]          iss_rd_i,
  output logic                iss_ready_o,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_rd_i,
  input  logic [XLEN-1:0]     wb_data_i,
  output logic                illegal_o
);

  localparam int AW = $clog2(NREGS);
  localparam logic [PEND_W-1:0] CMAX = '1;
  localparam logic [PEND_W-1:0] CONE = PEND_W'(1);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [PEND_W-1:0] cnt_q  [NREGS];
  logic [PEND_W-1:0] cnt_d  [NREGS];

  logic          wb_hit;
  logic          iss_legal;
  logic          iss_full;
  logic          claim;
  logic          any_bad;
  logic [AW-1:0] wb_idx;
  logic [AW-1:0] iss_idx;

  function automatic logic legal(input logic [4:0] a);
    return int'(a) < NREGS;
  endfunction

  assign wb_idx  = wb_rd_i[AW-1:0];
  assign iss_idx = iss_rd_i[AW-1:0];

  // x0 and out-of-range targets never touch storage or counters
  always_comb begin
    wb_hit      = wb_valid_i && legal(wb_rd_i) && (wb_rd_i != 5'd0);
    iss_legal   = legal(iss_rd_i) && (iss_rd_i != 5'd0);
    iss_full    = iss_legal && (cnt_q[iss_idx] == CMAX);
    iss_ready_o = !stall && !iss_full;
    claim       = iss_valid_i && iss_ready_o && iss_legal;
  end

  // read ports: stored value plus busy, optionally patched by writeback
  always_comb begin
    logic [4:0]        a;
    logic [PEND_W-1:0] c;
    a = '0;
    c = '0;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr_i[5*k +: 5];
      if (legal(a) && (a != 5'd0)) begin
        c = cnt_q[a[AW-1:0]];
        rd_data_o[k*XLEN +: XLEN] = regs_q[a[AW-1:0]];
        rd_busy_o[k] = (c != '0);
`ifdef RF_WB_BYPASS_EN
        if (wb_hit && (wb_rd_i == a)) begin
          rd_data_o[k*XLEN +: XLEN] = wb_data_i;
          if (c == CONE) rd_busy_o[k] = 1'b0;
        end
`endif
      end
    end
  end

  assign hazard_o = |rd_busy_o;

  // flag any out-of-range address seen on any port this cycle
  always_comb begin
    any_bad = (iss_valid_i && !legal(iss_rd_i))
           || (wb_valid_i && !legal(wb_rd_i));
    for (int k = 0; k < NRD; k++) begin
      if (!legal(rd_addr_i[5*k +: 5])) any_bad = 1'b1;
    end
  end

  // counter next state: claim +1, retire -1, both cancel, never underflow
  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      inc = claim && (iss_idx == AW'(r));
      dec = wb_hit && (wb_idx == AW'(r));
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CONE;
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CONE;
      end
    end
  end

  // register storage, written by the writeback port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_hit) begin
      regs_q[wb_idx] <= wb_data_i;
    end
  end

  // pending counters; reset drops every outstanding claim
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // one-cycle illegal-address report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_o <= 1'b0;
    else        illegal_o <= any_bad;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (RV32E sizing, 16 regs).
// A reference model is compared against the DUT on every negedge.
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int NREGS  = 16;
  localparam int NRD    = 2;
  localparam int PEND_W = 2;
  localparam int CMAX   = (1 << PEND_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                stall = 1'b0;
  logic [NRD*5-1:0]    rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                hazard;
  logic                iss_valid = 1'b0;
  logic [4:0]          iss_rd = '0;
  logic                iss_ready;
  logic                wb_valid = 1'b0;
  logic [4:0]          wb_rd = '0;
  logic [XLEN-1:0]     wb_data = '0;
  logic                illegal;

  int tests = 0;
  int fails = 0;
  bit run = 1'b0;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .PEND_W(PEND_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_busy_o(rd_busy), .hazard_o(hazard),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
    .iss_ready_o(iss_ready),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .wb_data_i(wb_data), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  // reference model: architectural values and outstanding-claim counts
  logic [XLEN-1:0] m_mem [32];
  int              m_cnt [32];
  logic            m_ill;

  function automatic bit ok_addr(int a);
    return (a != 0) && (a < NREGS);
  endfunction

  function automatic logic [XLEN-1:0] m_data(int a);
    if (!ok_addr(a)) return '0;
`ifdef RF_WB_BYPASS_EN
    if (wb_valid && int'(wb_rd) == a) return wb_data;
`endif
    return m_mem[a];
  endfunction

  function automatic bit m_busy(int a);
    if (!ok_addr(a)) return 1'b0;
`ifdef RF_WB_BYPASS_EN
    if (wb_valid && int'(wb_rd) == a && m_cnt[a] == 1) return 1'b0;
`endif
    return m_cnt[a] != 0;
  endfunction

  function automatic bit m_ready();
    if (stall) return 1'b0;
    if (!ok_addr(int'(iss_rd))) return 1'b1;
    return m_cnt[iss_rd] != CMAX;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  ir;
    int  wr;
    bit  cl;
    bit  wv;
    bit  bad;
    ir = int'(iss_rd);
    wr = int'(wb_rd);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] <= '0;
        m_cnt[i] <= 0;
      end
      m_ill <= 1'b0;
    end else begin
      cl = iss_valid && m_ready() && ok_addr(ir);
      wv = wb_valid && ok_addr(wr);
      if (wv) m_mem[wr] <= wb_data;
      if (!(cl && wv && ir == wr)) begin
        if (cl) m_cnt[ir] <= m_cnt[ir] + 1;
        if (wv && m_cnt[wr] > 0) m_cnt[wr] <= m_cnt[wr] - 1;
      end
      bad = (iss_valid && ir >= NREGS) || (wb_valid && wr >= NREGS);
      for (int k = 0; k < NRD; k++)
        if (int'(rd_addr[5*k +: 5]) >= NREGS) bad = 1'b1;
      m_ill <= bad;
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every cycle: all outputs against the model
  always @(negedge clk) begin
    bit hz;
    int a;
    hz = 1'b0;
    if (run) begin
      for (int k = 0; k < NRD; k++) begin
        a = int'(rd_addr[5*k +: 5]);
        check($sformatf("m_data%0d", k), 64'(rd_data[k*XLEN +: XLEN]),
              64'(m_data(a)));
        check($sformatf("m_busy%0d", k), 64'(rd_busy[k]), 64'(m_busy(a)));
        hz = hz | m_busy(a);
      end
      check("m_hazard", 64'(hazard), 64'(hz));
      check("m_ready", 64'(iss_ready), 64'(m_ready()));
      check("m_illegal", 64'(illegal), 64'(m_ill));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clr();
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic wb(int r, logic [XLEN-1:0] d);
    wb_valid = 1'b1;
    wb_rd    = 5'(r);
    wb_data  = d;
  endtask

  task automatic claim(int r);
    iss_valid = 1'b1;
    iss_rd    = 5'(r);
  endtask

  task automatic rd(int a0, int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  initial begin
    #2;
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_ready", 64'(iss_ready), 64'd1);
    check("rst_ill", 64'(illegal), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b1;

    // 1: write then read back
    wb(5, 32'hDEADBEEF);
    tick();
    clr();
    rd(5, 0);
    settle();
    check("t1_data", 64'(rd_data[XLEN-1:0]), 64'hDEADBEEF);
    check("t1_busy", 64'(rd_busy[0]), 64'd0);
    tick();

    // 2: claim, then read busy, then retire
    claim(7);
    tick();
    clr();
    rd(7, 0);
    settle();
    check("t2_busy", 64'(rd_busy[0]), 64'd1);
    check("t2_hazard", 64'(hazard), 64'd1);
    tick();
    wb(7, 32'h12);
    settle();
`ifdef RF_WB_BYPASS_EN
    check("t2_byp_data", 64'(rd_data[XLEN-1:0]), 64'h12);
    check("t2_byp_busy", 64'(rd_busy[0]), 64'd0);
`else
    check("t2_nb_busy", 64'(rd_busy[0]), 64'd1);
    check("t2_nb_data", 64'(rd_data[XLEN-1:0]), 64'h0);
`endif
    tick();
    clr();
    settle();
    check("t2_data", 64'(rd_data[XLEN-1:0]), 64'h12);
    check("t2_busy2", 64'(rd_busy[0]), 64'd0);

    // 3: saturate x3, then drain past zero
    claim(3);
    tick();
    tick();
    tick();
    clr();
    rd(0, 3);
    settle();
    check("t3_full", 64'(iss_ready), 64'd0);
    check("t3_busy", 64'(rd_busy[1]), 64'd1);
    tick();
    wb(3, 32'h31);
    tick();
    clr();
    settle();
    check("t3_ready", 64'(iss_ready), 64'd1);
    check("t3_busy2", 64'(rd_busy[1]), 64'd1);
    wb(3, 32'h32);
    tick();
    tick();
    tick();
    clr();
    settle();
    check("t3_empty", 64'(rd_busy[1]), 64'd0);
    check("t3_data", 64'(rd_data[2*XLEN-1:XLEN]), 64'h32);
    claim(3);
    tick();
    clr();
    wb(3, 32'h33);
    tick();
    clr();
    settle();
    check("t3_noundf", 64'(rd_busy[1]), 64'd0);

    // 4: claim and retire x9 together keep it busy
    claim(9);
    tick();
    wb(9, 32'h99);
    tick();
    clr();
    rd(9, 0);
    settle();
    check("t4_busy", 64'(rd_busy[0]), 64'd1);
    wb(9, 32'h9A);
    tick();
    clr();
    settle();
    check("t4_clear", 64'(rd_busy[0]), 64'd0);
    check("t4_data", 64'(rd_data[XLEN-1:0]), 64'h9A);

    // stall blocks claims
    stall = 1'b1;
    claim(10);
    settle();
    check("stall_rdy", 64'(iss_ready), 64'd0);
    tick();
    clr();
    rd(10, 0);
    settle();
    check("stall_busy", 64'(rd_busy[0]), 64'd0);

    // 5: x0 and out-of-range addresses
    wb(0, 32'hFFFFFFFF);
    tick();
    clr();
    rd(0, 20);
    settle();
    check("t5_x0", 64'(rd_data[XLEN-1:0]), 64'd0);
    check("t5_oob", 64'(rd_data[2*XLEN-1:XLEN]), 64'd0);
    check("t5_ill0", 64'(illegal), 64'd0);
    tick();
    rd(0, 0);
    settle();
    check("t5_ill1", 64'(illegal), 64'd1);
    wb(25, 32'h5);
    claim(21);
    settle();
    check("t5_oob_rdy", 64'(iss_ready), 64'd1);
    tick();
    clr();
    tick();
    settle();
    check("t5_ill2", 64'(illegal), 64'd0);

    // 6: async reset drops claims and clears storage
    claim(4);
    tick();
    claim(5);
    tick();
    clr();
    rd(4, 5);
    #1;
    check("t6_busy", 64'(rd_busy), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rbusy", 64'(rd_busy), 64'd0);
    check("t6_rhaz", 64'(hazard), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(7, 5);
    settle();
    check("t6_x7", 64'(rd_data[XLEN-1:0]), 64'd0);
    check("t6_x5", 64'(rd_data[2*XLEN-1:XLEN]), 64'd0);
    tick();

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
